// File: rtl/tdm_mux4_tx_pkg.sv
// Shared constants for the four-channel TDM transmitter.
package tdm_mux4_tx_pkg;
    localparam int   NUM_CH = 4;
    localparam int   SEL_W  = 2;
    localparam logic D_IDLE = 1'b1;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/tdm_tx_lane.sv
// One transmit channel: holds the word, shifts it MSB-first on each served slot,
// and retires itself after the last bit.
module tdm_tx_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             shift,
    output logic             msb,
    output logic             active,
    output logic             last
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load && !active) begin
            sr     <= data;
            cnt    <= '0;
            active <= 1'b1;
        end else if (shift && active) begin
            sr  <= sr << 1;
            cnt <= cnt + CW'(1);
            if (last)
                active <= 1'b0;
        end
    end

    assign msb  = sr[WIDTH-1];
    assign last = (cnt == CW'(WIDTH-1));
endmodule

// File: rtl/tdm_mux4_tx.sv
// Round-robin slot timer driving the demux select/data/enable, with one
// serialising lane per channel.
module tdm_mux4_tx
    import tdm_mux4_tx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SLOT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    output logic [NUM_CH-1:0]       ready,
    output logic [SEL_W-1:0]        A,
    output logic                    D,
    output logic                    E
);
    localparam int TW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic [TW-1:0]     tcnt;
    logic              bnd;
    sel_t              nxt;
    logic [NUM_CH-1:0] shift;
    logic [NUM_CH-1:0] msb;
    logic [NUM_CH-1:0] active;
    // Lanes retire themselves; the end-of-word flag is not needed up here.
    logic [NUM_CH-1:0] last_unused;

    assign bnd   = (tcnt == TW'(SLOT_CYCLES-1));
    assign nxt   = A + 1'b1;
    assign ready = ~active;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        // Only the channel being served this slot advances, and only if it sent a bit.
        assign shift[i] = bnd && E && (A == SEL_W'(i));

        tdm_tx_lane #(.WIDTH(WIDTH)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load[i]),
            .data   (data_in[i*WIDTH +: WIDTH]),
            .shift  (shift[i]),
            .msb    (msb[i]),
            .active (active[i]),
            .last   (last_unused[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            A    <= '0;
            E    <= 1'b0;
            D    <= D_IDLE;
        end else if (bnd) begin
            tcnt <= '0;
            A    <= nxt;
            E    <= active[nxt];
            D    <= active[nxt] ? msb[nxt] : D_IDLE;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end
endmodule
